if_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register. It drives the decoder: ID takes Op=IfId_Instr[31:26] and Funct=IfId_Instr[5:0].
//  It owns the PC, issues requests to instruction memory, applies branch/jump redirects, and honours stalls from the hazard unit.
//  It stops fetching when ID decodes HALT.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/if_stage_if.sv | 10 +
 rtl/if_stage_hold_buffer.sv | 52 +++++
 rtl/if_stage.sv | 167 ++++++++++++++++
 tb/tb_if_stage.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct constants, the NOP word and the
// fetch-stage state encoding.
package mips_pkg;
   localparam logic [5:0] OP_TIPOR = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      FS_REQ    = 2'b00,
      FS_DRAIN  = 2'b01,
      FS_HALTED = 2'b10
   } fetch_state_e;
endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/ack channel between the fetch stage and imem.
interface if_stage_if #(parameter int ADDR_W = 32);
   logic              ImemReq;
   logic [ADDR_W-1:0] ImemAddr;
   logic              ImemAck;
   logic [31:0]       ImemData;

   modport master (output ImemReq, ImemAddr, input ImemAck, ImemData);
   modport slave  (input ImemReq, ImemAddr, output ImemAck, ImemData);
endinterface

// File: rtl/if_stage_hold_buffer.sv
// One-entry {instr, pcplus4} skid buffer that catches a fetch arriving
// while ID is stalled.
module if_hold_buffer #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic              unload,
   input  logic              clear,
   input  logic [31:0]       in_instr,
   input  logic [ADDR_W-1:0] in_pcplus4,
   output logic              valid,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] pcplus4
);
   logic              valid_q, valid_d;
   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] pcplus4_q, pcplus4_d;

   always_comb begin
      valid_d   = valid_q;
      instr_d   = instr_q;
      pcplus4_d = pcplus4_q;
      // clear wins so a redirect always kills a buffered wrong-path word
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d   = 1'b1;
         instr_d   = in_instr;
         pcplus4_d = in_pcplus4;
      end else if (unload) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q   <= 1'b0;
         instr_q   <= '0;
         pcplus4_q <= '0;
      end else begin
         valid_q   <= valid_d;
         instr_q   <= instr_d;
         pcplus4_q <= pcplus4_d;
      end
   end

   assign valid   = valid_q;
   assign instr   = instr_q;
   assign pcplus4 = pcplus4_q;
endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register: PC, imem handshake,
// redirect/drain handling, stall hold buffer and halt.
module if_stage
   import mips_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              Stall,
   input  logic              BranchTaken,
   input  logic [ADDR_W-1:0] BranchTarget,
   input  logic              Jump,
   input  logic [ADDR_W-1:0] JumpTarget,
   input  logic              Halt,
   if_stage_if.master        imem,
   output logic [31:0]       IfId_Instr,
   output logic [ADDR_W-1:0] IfId_PCPlus4,
   output logic              IfId_Valid,
   output logic              Halted
);
   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
   logic              drain_halt_q, drain_halt_d;
   logic [31:0]       ifid_instr_q, ifid_instr_d;
   logic [ADDR_W-1:0] ifid_pcplus4_q, ifid_pcplus4_d;
   logic              ifid_valid_q, ifid_valid_d;

   logic              hold_load, hold_unload, hold_clear, hold_valid;
   logic [31:0]       hold_instr;
   logic [ADDR_W-1:0] hold_pcplus4;

   logic              redirect, imem_req, ack_ok;
   logic [ADDR_W-1:0] target, pc_plus4;

   assign redirect = BranchTaken | Jump;
   assign target   = BranchTaken ? BranchTarget : JumpTarget;
   assign pc_plus4 = pc_q + ADDR_W'(4);
   assign imem_req = reset_n && ((state_q == FS_DRAIN) ||
                                 (state_q == FS_REQ && !hold_valid));
   // an ack only counts against a live request; stray acks are ignored
   assign ack_ok   = imem.ImemAck && imem_req;

   if_hold_buffer #(.ADDR_W(ADDR_W)) u_hold (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (hold_load),
      .unload     (hold_unload),
      .clear      (hold_clear),
      .in_instr   (imem.ImemData),
      .in_pcplus4 (pc_plus4),
      .valid      (hold_valid),
      .instr      (hold_instr),
      .pcplus4    (hold_pcplus4)
   );

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      pend_pc_d      = pend_pc_q;
      drain_halt_d   = drain_halt_q;
      ifid_instr_d   = ifid_instr_q;
      ifid_pcplus4_d = ifid_pcplus4_q;
      ifid_valid_d   = ifid_valid_q;
      hold_load      = 1'b0;
      hold_unload    = 1'b0;
      hold_clear     = 1'b0;
      case (state_q)
         FS_REQ: begin
            if (redirect) begin
               ifid_valid_d = 1'b0;
               ifid_instr_d = NOP_WORD;
               hold_clear   = 1'b1;
               if (imem_req && !imem.ImemAck) begin
                  pend_pc_d    = target;
                  drain_halt_d = 1'b0;
                  state_d      = FS_DRAIN;
               end else begin
                  pc_d = target;
               end
            end else if (Halt) begin
               ifid_valid_d = 1'b0;
               ifid_instr_d = NOP_WORD;
               hold_clear   = 1'b1;
               if (imem_req && !imem.ImemAck) begin
                  drain_halt_d = 1'b1;
                  state_d      = FS_DRAIN;
               end else begin
                  state_d = FS_HALTED;
               end
            end else if (ack_ok) begin
               pc_d = pc_plus4;
               if (Stall) begin
                  hold_load = 1'b1;
               end else begin
                  ifid_instr_d   = imem.ImemData;
                  ifid_pcplus4_d = pc_plus4;
                  ifid_valid_d   = 1'b1;
               end
            end else if (!Stall) begin
               if (hold_valid) begin
                  ifid_instr_d   = hold_instr;
                  ifid_pcplus4_d = hold_pcplus4;
                  ifid_valid_d   = 1'b1;
                  hold_unload    = 1'b1;
               end else begin
                  ifid_valid_d = 1'b0;
               end
            end
         end
         FS_DRAIN: begin
            // address stays at pc_q until the old request is acked
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_WORD;
            if (redirect) begin
               pend_pc_d    = target;
               drain_halt_d = 1'b0;
               if (imem.ImemAck) begin
                  pc_d    = target;
                  state_d = FS_REQ;
               end
            end else if (imem.ImemAck) begin
               if (drain_halt_q) begin
                  state_d = FS_HALTED;
               end else begin
                  pc_d    = pend_pc_q;
                  state_d = FS_REQ;
               end
            end
         end
         FS_HALTED: begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_WORD;
         end
         default: state_d = FS_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= FS_REQ;
         pc_q           <= RESET_PC;
         pend_pc_q      <= RESET_PC;
         drain_halt_q   <= 1'b0;
         ifid_instr_q   <= NOP_WORD;
         ifid_pcplus4_q <= '0;
         ifid_valid_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         pend_pc_q      <= pend_pc_d;
         drain_halt_q   <= drain_halt_d;
         ifid_instr_q   <= ifid_instr_d;
         ifid_pcplus4_q <= ifid_pcplus4_d;
         ifid_valid_q   <= ifid_valid_d;
      end
   end

   assign imem.ImemReq  = imem_req;
   assign imem.ImemAddr = pc_q;
   assign IfId_Instr    = ifid_instr_q;
   assign IfId_PCPlus4  = ifid_pcplus4_q;
   assign IfId_Valid    = ifid_valid_q;
   assign Halted        = (state_q == FS_HALTED);
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch timing, wait states, stall hold,
// redirect drain, halt, redirect priority and PC wrap.
module tb_if_stage;
   logic        clk = 1'b0;
   logic        reset_n, Stall, BranchTaken, Jump, Halt;
   logic [31:0] BranchTarget, JumpTarget;
   logic [31:0] IfId_Instr, IfId_PCPlus4;
   logic        IfId_Valid, Halted;
   int          checks = 0;
   int          errors = 0;

   if_stage_if #(.ADDR_W(32)) imem ();

   if_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset_n(reset_n), .Stall(Stall),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .Jump(Jump), .JumpTarget(JumpTarget), .Halt(Halt),
      .imem(imem),
      .IfId_Instr(IfId_Instr), .IfId_PCPlus4(IfId_PCPlus4),
      .IfId_Valid(IfId_Valid), .Halted(Halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; Stall = 0; BranchTaken = 0; Jump = 0; Halt = 0;
      BranchTarget = 0; JumpTarget = 0; imem.ImemAck = 0; imem.ImemData = 0;
      tick(); tick();
      checks++; if (imem.ImemReq !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem.ImemReq); end
      checks++; if (imem.ImemAddr !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", imem.ImemAddr); end
      checks++; if (IfId_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", IfId_Valid); end
      checks++; if (IfId_Instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", IfId_Instr); end
      checks++; if (IfId_PCPlus4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h exp 0", IfId_PCPlus4); end
      checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", Halted); end
      reset_n = 1'b1; #1;
      checks++; if (imem.ImemReq !== 1'b1) begin errors++; $display("FAIL rst_release_req got %b exp 1", imem.ImemReq); end
   endtask

   task automatic test_zero_wait();
      imem.ImemAck = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (imem.ImemAddr !== 32'(4*i)) begin errors++; $display("FAIL zw_addr%0d got %h exp %h", i, imem.ImemAddr, 4*i); end
         imem.ImemData = 32'hA000_0000 | 32'(i);
         tick();
         checks++; if (IfId_PCPlus4 !== 32'(4*(i+1))) begin errors++; $display("FAIL zw_pc4_%0d got %h exp %h", i, IfId_PCPlus4, 4*(i+1)); end
         checks++; if (IfId_Instr !== (32'hA000_0000 | 32'(i))) begin errors++; $display("FAIL zw_instr%0d got %h", i, IfId_Instr); end
         checks++; if (IfId_Valid !== 1'b1) begin errors++; $display("FAIL zw_valid%0d got %b exp 1", i, IfId_Valid); end
      end
      imem.ImemAck = 1'b0;
   endtask

   task automatic test_wait_states();
      for (int i = 0; i < 3; i++) begin
         checks++; if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'hC) begin errors++; $display("FAIL ws_hold%0d got req %b addr %h exp 1 c", i, imem.ImemReq, imem.ImemAddr); end
         tick();
      end
      checks++; if (IfId_PCPlus4 !== 32'hC || IfId_Valid !== 1'b0) begin errors++; $display("FAIL ws_noupd got pc4 %h v %b exp c 0", IfId_PCPlus4, IfId_Valid); end
      checks++; if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'hC) begin errors++; $display("FAIL ws_hold3 got req %b addr %h exp 1 c", imem.ImemReq, imem.ImemAddr); end
      imem.ImemAck = 1'b1; imem.ImemData = 32'hB000_000C;
      tick();
      imem.ImemAck = 1'b0;
      checks++; if (IfId_PCPlus4 !== 32'h10 || IfId_Instr !== 32'hB000_000C || IfId_Valid !== 1'b1) begin errors++; $display("FAIL ws_upd got pc4 %h instr %h v %b exp 10 b000000c 1", IfId_PCPlus4, IfId_Instr, IfId_Valid); end
      tick();
      checks++; if (imem.ImemAddr !== 32'h10 || IfId_Valid !== 1'b0) begin errors++; $display("FAIL ws_once got addr %h v %b exp 10 0", imem.ImemAddr, IfId_Valid); end
   endtask

   task automatic test_stall_hold();
      imem.ImemAck = 1'b1; imem.ImemData = 32'h2008_0005; Stall = 1'b1;
      tick();
      imem.ImemAck = 1'b0;
      checks++; if (IfId_PCPlus4 !== 32'h10 || IfId_Valid !== 1'b0) begin errors++; $display("FAIL st_unch got pc4 %h v %b exp 10 0", IfId_PCPlus4, IfId_Valid); end
      checks++; if (imem.ImemReq !== 1'b0 || imem.ImemAddr !== 32'h14) begin errors++; $display("FAIL st_req got req %b addr %h exp 0 14", imem.ImemReq, imem.ImemAddr); end
      tick();
      checks++; if (imem.ImemReq !== 1'b0 || IfId_PCPlus4 !== 32'h10) begin errors++; $display("FAIL st_hold2 got req %b pc4 %h exp 0 10", imem.ImemReq, IfId_PCPlus4); end
      Stall = 1'b0;
      tick();
      checks++; if (IfId_Instr !== 32'h2008_0005 || IfId_PCPlus4 !== 32'h14 || IfId_Valid !== 1'b1) begin errors++; $display("FAIL st_release got instr %h pc4 %h v %b exp 20080005 14 1", IfId_Instr, IfId_PCPlus4, IfId_Valid); end
      checks++; if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'h14) begin errors++; $display("FAIL st_resume got req %b addr %h exp 1 14", imem.ImemReq, imem.ImemAddr); end
   endtask

   task automatic test_jump_drain();
      reset_n = 1'b0; tick(); reset_n = 1'b1;
      imem.ImemAck = 1'b1; imem.ImemData = 32'h1;
      tick(); tick();
      imem.ImemAck = 1'b0;
      checks++; if (imem.ImemAddr !== 32'h8) begin errors++; $display("FAIL jd_pre got addr %h exp 8", imem.ImemAddr); end
      Jump = 1'b1; JumpTarget = 32'h40;
      tick();
      Jump = 1'b0;
      checks++; if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'h8) begin errors++; $display("FAIL jd_drain got req %b addr %h exp 1 8", imem.ImemReq, imem.ImemAddr); end
      checks++; if (IfId_Valid !== 1'b0 || IfId_Instr !== 32'h0) begin errors++; $display("FAIL jd_bubble got v %b instr %h exp 0 0", IfId_Valid, IfId_Instr); end
      tick();
      checks++; if (imem.ImemAddr !== 32'h8) begin errors++; $display("FAIL jd_drain2 got addr %h exp 8", imem.ImemAddr); end
      imem.ImemAck = 1'b1; imem.ImemData = 32'hDEAD_BEEF;
      tick();
      imem.ImemAck = 1'b0;
      checks++; if (imem.ImemAddr !== 32'h40 || IfId_Valid !== 1'b0 || IfId_Instr !== 32'h0) begin errors++; $display("FAIL jd_drop got addr %h v %b instr %h exp 40 0 0", imem.ImemAddr, IfId_Valid, IfId_Instr); end
      imem.ImemAck = 1'b1; imem.ImemData = 32'h0000_C0DE;
      tick();
      imem.ImemAck = 1'b0;
      checks++; if (IfId_Instr !== 32'h0000_C0DE || IfId_PCPlus4 !== 32'h44 || IfId_Valid !== 1'b1) begin errors++; $display("FAIL jd_target got instr %h pc4 %h v %b exp c0de 44 1", IfId_Instr, IfId_PCPlus4, IfId_Valid); end
   endtask

   task automatic test_halt();
      imem.ImemAck = 1'b1; imem.ImemData = 32'hFC00_0000; Halt = 1'b1;
      tick();
      imem.ImemAck = 1'b0; Halt = 1'b0;
      checks++; if (imem.ImemReq !== 1'b0 || Halted !== 1'b1 || IfId_Valid !== 1'b0) begin errors++; $display("FAIL h_stop got req %b halted %b v %b exp 0 1 0", imem.ImemReq, Halted, IfId_Valid); end
      BranchTaken = 1'b1; BranchTarget = 32'h300;
      tick();
      BranchTaken = 1'b0;
      checks++; if (Halted !== 1'b1 || imem.ImemReq !== 1'b0 || imem.ImemAddr !== 32'h44) begin errors++; $display("FAIL h_nobr got halted %b req %b addr %h exp 1 0 44", Halted, imem.ImemReq, imem.ImemAddr); end
      reset_n = 1'b0;
      tick();
      checks++; if (Halted !== 1'b0 || imem.ImemAddr !== 32'h0 || imem.ImemReq !== 1'b0) begin errors++; $display("FAIL h_reset got halted %b addr %h req %b exp 0 0 0", Halted, imem.ImemAddr, imem.ImemReq); end
      reset_n = 1'b1; #1;
      checks++; if (imem.ImemReq !== 1'b1) begin errors++; $display("FAIL h_restart got req %b exp 1", imem.ImemReq); end
   endtask

   task automatic test_priority();
      imem.ImemAck = 1'b1; imem.ImemData = 32'h7;
      tick();
      checks++; if (IfId_Valid !== 1'b1 || imem.ImemAddr !== 32'h4) begin errors++; $display("FAIL pr_pre got v %b addr %h exp 1 4", IfId_Valid, imem.ImemAddr); end
      imem.ImemData = 32'h1111_1111;
      BranchTaken = 1'b1; BranchTarget = 32'h100; Jump = 1'b1; JumpTarget = 32'h200; Stall = 1'b1;
      tick();
      imem.ImemAck = 1'b0; BranchTaken = 1'b0; Jump = 1'b0; Stall = 1'b0;
      checks++; if (imem.ImemAddr !== 32'h100 || imem.ImemReq !== 1'b1) begin errors++; $display("FAIL pr_target got addr %h req %b exp 100 1", imem.ImemAddr, imem.ImemReq); end
      checks++; if (IfId_Valid !== 1'b0 || IfId_Instr !== 32'h0) begin errors++; $display("FAIL pr_bubble got v %b instr %h exp 0 0", IfId_Valid, IfId_Instr); end
   endtask

   task automatic test_wrap();
      imem.ImemAck = 1'b1; imem.ImemData = 32'h5; Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
      tick();
      Jump = 1'b0;
      checks++; if (imem.ImemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_jump got addr %h exp fffffffc", imem.ImemAddr); end
      imem.ImemData = 32'h6;
      tick();
      imem.ImemAck = 1'b0;
      checks++; if (IfId_PCPlus4 !== 32'h0 || imem.ImemAddr !== 32'h0 || IfId_Instr !== 32'h6) begin errors++; $display("FAIL wr_wrap got pc4 %h addr %h instr %h exp 0 0 6", IfId_PCPlus4, imem.ImemAddr, IfId_Instr); end
   endtask

   task automatic test_halt_drain();
      Halt = 1'b1;
      tick();
      Halt = 1'b0;
      checks++; if (Halted !== 1'b0 || imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'h0) begin errors++; $display("FAIL hd_drain got halted %b req %b addr %h exp 0 1 0", Halted, imem.ImemReq, imem.ImemAddr); end
      imem.ImemAck = 1'b1; imem.ImemData = 32'h9;
      tick();
      imem.ImemAck = 1'b0;
      checks++; if (Halted !== 1'b1 || imem.ImemReq !== 1'b0 || IfId_Valid !== 1'b0) begin errors++; $display("FAIL hd_halt got halted %b req %b v %b exp 1 0 0", Halted, imem.ImemReq, IfId_Valid); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stall_hold();
      test_jump_drain();
      test_halt();
      test_priority();
      test_wrap();
      test_halt_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
